// File: rtl/mc_control_fsm.sv
// Multicycle control FSM for the 16-bit RISC core: sequences fetch, decode and execute of every instruction.
// Latency: control word for state S is registered and visible for the whole cycle the FSM sits in S.
// Backpressure: none; the FSM advances every cycle and the datapath is assumed always ready.
//
// Ports:
//   clk, rst_n      core clock (rising edge), asynchronous active-low reset
//   IRout, compare  instruction register contents and ALU A==B flag from the datapath
//   Mux*, CZ_en, ALU_op, wIR, wAtmp   registered datapath control word
//   counter         LM/SM register index, halted   core stopped on an illegal opcode
//
// Optional feature: define ILLEGAL_TRAP_EN to trap undefined opcodes into a HALT
// state (exit by reset only); otherwise undefined opcodes behave as NOPs.
module mc_control_fsm #(
    parameter logic [4:0] RESET_STATE = 5'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] IRout,
    input  logic        compare,
    output logic [2:0]  Mux1_alu_B,
    output logic [2:0]  Mux2_alu_A,
    output logic [1:0]  Mux3_RF_wen,
    output logic [2:0]  Mux4_RF_wadd,
    output logic [1:0]  Mux5_RF_read2,
    output logic        Mux6_RF_dataIn,
    output logic [1:0]  Mux8_memwrite,
    output logic        Mux9_memDataIn,
    output logic        CZ_en,
    output logic        ALU_op,
    output logic        wIR,
    output logic        wAtmp,
    output logic [2:0]  counter,
    output logic        halted
);

    typedef enum logic [4:0] {
        FETCH_ADDR = 5'd0,
        FETCH_IR   = 5'd1,
        PC_WB      = 5'd2,
        DECODE     = 5'd3,
        ALU_RR     = 5'd4,
        RR_WB      = 5'd5,
        ALU_RI     = 5'd6,
        RI_WB      = 5'd7,
        LHI        = 5'd8,
        LHI_WB     = 5'd9,
        ADDR       = 5'd10,
        LW_WB      = 5'd11,
        SW_MEM     = 5'd12,
        LMSM_ADDR  = 5'd13,
        LMSM_XFER  = 5'd14,
        BEQ        = 5'd15,
        BR_CALC    = 5'd16,
        BR_WB      = 5'd17,
        JAL        = 5'd18,
        JLR        = 5'd19,
        JAL_LINK   = 5'd20,
        JLR_CALC   = 5'd21,
        HALT       = 5'd22
    } state_t;

    // Datapath control word, registered as one unit.
    typedef struct packed {
        logic [2:0] alu_b;
        logic [2:0] alu_a;
        logic [1:0] rf_wen;
        logic [2:0] rf_wadd;
        logic [1:0] rf_read2;
        logic       rf_din;
        logic [1:0] mem_wr;
        logic       mem_din;
        logic       cz_en;
        logic       alu_op;
        logic       w_ir;
        logic       w_atmp;
    } ctrl_t;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_ADI = 4'b0001;
    localparam logic [3:0] OP_NDU = 4'b0010;
    localparam logic [3:0] OP_LHI = 4'b0011;
    localparam logic [3:0] OP_LW  = 4'b0100;
    localparam logic [3:0] OP_SW  = 4'b0101;
    localparam logic [3:0] OP_LM  = 4'b0110;
    localparam logic [3:0] OP_SM  = 4'b0111;
    localparam logic [3:0] OP_JAL = 4'b1000;
    localparam logic [3:0] OP_JLR = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1100;

    state_t     state_q, state_d;
    logic [2:0] counter_q, counter_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic [3:0] opcode;

    assign opcode = IRout[15:12];

    // Operand fields are consumed by the datapath, not by the controller.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IRout[11:0];

    // ------------------------------------------------------------------
    // Next-state and counter logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        case (state_q)
            FETCH_ADDR: state_d = FETCH_IR;
            FETCH_IR:   state_d = PC_WB;
            PC_WB:      state_d = DECODE;
            DECODE: begin
                counter_d = 3'd0;
                case (opcode)
                    OP_ADD, OP_NDU: state_d = ALU_RR;
                    OP_ADI:         state_d = ALU_RI;
                    OP_LHI:         state_d = LHI;
                    OP_LW, OP_SW:   state_d = ADDR;
                    OP_LM, OP_SM:   state_d = LMSM_ADDR;
                    OP_BEQ:         state_d = BEQ;
                    OP_JAL:         state_d = JAL;
                    OP_JLR:         state_d = JLR;
`ifdef ILLEGAL_TRAP_EN
                    default:        state_d = HALT;
`else
                    default:        state_d = FETCH_ADDR;
`endif
                endcase
            end
            ALU_RR:    state_d = RR_WB;
            RR_WB:     state_d = FETCH_ADDR;
            ALU_RI:    state_d = RI_WB;
            RI_WB:     state_d = FETCH_ADDR;
            LHI:       state_d = LHI_WB;
            LHI_WB:    state_d = FETCH_ADDR;
            // opcode bit 0 separates SW from LW
            ADDR:      state_d = opcode[0] ? SW_MEM : LW_WB;
            LW_WB:     state_d = FETCH_ADDR;
            SW_MEM:    state_d = FETCH_ADDR;
            LMSM_ADDR: state_d = LMSM_XFER;
            LMSM_XFER: begin
                // All eight indices are walked; the datapath masks with IR[counter].
                if (counter_q == 3'd7) begin
                    counter_d = 3'd0;
                    state_d   = FETCH_ADDR;
                end else begin
                    counter_d = counter_q + 3'd1;
                    state_d   = LMSM_ADDR;
                end
            end
            BEQ:       state_d = compare ? BR_CALC : FETCH_ADDR;
            BR_CALC:   state_d = BR_WB;
            BR_WB:     state_d = FETCH_ADDR;
            JAL:       state_d = JAL_LINK;
            JLR:       state_d = JAL_LINK;
            // opcode bit 0 separates JLR (register target) from JAL (PC-relative)
            JAL_LINK:  state_d = opcode[0] ? JLR_CALC : BR_CALC;
            JLR_CALC:  state_d = BR_WB;
`ifdef ILLEGAL_TRAP_EN
            HALT:      state_d = HALT;
`endif
            default:   state_d = FETCH_ADDR;
        endcase
    end

    // ------------------------------------------------------------------
    // Control word for the state being entered; registered below so it
    // lines up with the cycle spent in that state.
    // ------------------------------------------------------------------
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            FETCH_ADDR: begin
                ctrl_d.rf_read2 = 2'd2;
                ctrl_d.alu_b    = 3'd2;
                ctrl_d.alu_a    = 3'd0;
            end
            FETCH_IR: begin
                ctrl_d.w_ir     = 1'b1;
                ctrl_d.rf_read2 = 2'd2;
                ctrl_d.alu_b    = 3'd2;
                ctrl_d.alu_a    = 3'd1;
            end
            PC_WB: begin
                ctrl_d.rf_wen  = 2'd1;
                ctrl_d.rf_wadd = 3'd3;
                ctrl_d.rf_din  = 1'b1;
            end
            DECODE: ctrl_d.w_atmp = 1'b1;
            ALU_RR: begin
                ctrl_d.alu_a    = 3'd5;
                ctrl_d.alu_b    = 3'd2;
                ctrl_d.rf_read2 = 2'd0;
                ctrl_d.alu_op   = opcode[1];
                ctrl_d.cz_en    = 1'b1;
            end
            RR_WB: begin
                ctrl_d.rf_wen  = 2'd2;
                ctrl_d.rf_wadd = 3'd1;
                ctrl_d.rf_din  = 1'b1;
            end
            ALU_RI: begin
                ctrl_d.alu_a = 3'd5;
                ctrl_d.alu_b = 3'd3;
                ctrl_d.cz_en = 1'b1;
            end
            RI_WB: begin
                ctrl_d.rf_wen  = 2'd1;
                ctrl_d.rf_wadd = 3'd4;
                ctrl_d.rf_din  = 1'b1;
            end
            LHI: begin
                ctrl_d.alu_a = 3'd2;
                ctrl_d.alu_b = 3'd0;
            end
            LHI_WB: begin
                ctrl_d.rf_wen  = 2'd1;
                ctrl_d.rf_wadd = 3'd0;
                ctrl_d.rf_din  = 1'b1;
            end
            ADDR: begin
                ctrl_d.alu_a    = 3'd3;
                ctrl_d.alu_b    = 3'd2;
                ctrl_d.rf_read2 = 2'd0;
            end
            LW_WB: begin
                ctrl_d.rf_wen  = 2'd1;
                ctrl_d.rf_wadd = 3'd0;
                ctrl_d.rf_din  = 1'b0;
            end
            SW_MEM: begin
                ctrl_d.mem_wr  = 2'd1;
                ctrl_d.mem_din = 1'b0;
            end
            LMSM_ADDR: begin
                ctrl_d.alu_a = 3'd6;
                ctrl_d.alu_b = 3'd4;
            end
            LMSM_XFER: begin
                if (opcode[0]) begin
                    ctrl_d.mem_wr   = 2'd2;
                    ctrl_d.rf_read2 = 2'd1;
                    ctrl_d.mem_din  = 1'b1;
                end else begin
                    ctrl_d.rf_wen  = 2'd3;
                    ctrl_d.rf_wadd = 3'd2;
                    ctrl_d.rf_din  = 1'b0;
                end
            end
            BEQ: begin
                ctrl_d.alu_a    = 3'd5;
                ctrl_d.alu_b    = 3'd2;
                ctrl_d.rf_read2 = 2'd0;
            end
            BR_CALC: begin
                // JAL uses the 9-bit offset, BEQ the 6-bit one; both add to R7 (= PC+1).
                ctrl_d.alu_a    = (opcode == OP_JAL) ? 3'd4 : 3'd3;
                ctrl_d.rf_read2 = 2'd2;
                ctrl_d.alu_b    = 3'd2;
            end
            BR_WB: begin
                ctrl_d.rf_wen  = 2'd1;
                ctrl_d.rf_wadd = 3'd3;
                ctrl_d.rf_din  = 1'b1;
            end
            JAL, JLR: begin
                ctrl_d.rf_read2 = 2'd2;
                ctrl_d.alu_b    = 3'd2;
                ctrl_d.alu_a    = 3'd0;
            end
            JAL_LINK: begin
                ctrl_d.rf_wen  = 2'd1;
                ctrl_d.rf_wadd = 3'd0;
                ctrl_d.rf_din  = 1'b1;
            end
            JLR_CALC: begin
                ctrl_d.alu_a    = 3'd0;
                ctrl_d.rf_read2 = 2'd0;
                ctrl_d.alu_b    = 3'd2;
            end
            default: ctrl_d = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // State, counter and control-word registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= state_t'(RESET_STATE);
            counter_q <= 3'd0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            ctrl_q    <= ctrl_d;
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic halted_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= (state_d == HALT);
        end
    end
    assign halted = halted_q;
`else
    assign halted = 1'b0;
`endif

    assign Mux1_alu_B     = ctrl_q.alu_b;
    assign Mux2_alu_A     = ctrl_q.alu_a;
    assign Mux3_RF_wen    = ctrl_q.rf_wen;
    assign Mux4_RF_wadd   = ctrl_q.rf_wadd;
    assign Mux5_RF_read2  = ctrl_q.rf_read2;
    assign Mux6_RF_dataIn = ctrl_q.rf_din;
    assign Mux8_memwrite  = ctrl_q.mem_wr;
    assign Mux9_memDataIn = ctrl_q.mem_din;
    assign CZ_en          = ctrl_q.cz_en;
    assign ALU_op         = ctrl_q.alu_op;
    assign wIR            = ctrl_q.w_ir;
    assign wAtmp          = ctrl_q.w_atmp;
    assign counter        = counter_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm: each cycle's full control word is compared against hand-built values.
// Latency: outputs sampled on the falling edge, one vector per FSM state visited.
// Backpressure: none; stimulus is a fixed cycle-by-cycle script.
module tb_mc_control_fsm;

    logic        clk;
    logic        rst_n;
    logic [15:0] IRout;
    logic        compare;
    logic [2:0]  Mux1_alu_B;
    logic [2:0]  Mux2_alu_A;
    logic [1:0]  Mux3_RF_wen;
    logic [2:0]  Mux4_RF_wadd;
    logic [1:0]  Mux5_RF_read2;
    logic        Mux6_RF_dataIn;
    logic [1:0]  Mux8_memwrite;
    logic        Mux9_memDataIn;
    logic        CZ_en;
    logic        ALU_op;
    logic        wIR;
    logic        wAtmp;
    logic [2:0]  counter;
    logic        halted;

    int n_vec = 0;
    int n_err = 0;

    mc_control_fsm dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .IRout          (IRout),
        .compare        (compare),
        .Mux1_alu_B     (Mux1_alu_B),
        .Mux2_alu_A     (Mux2_alu_A),
        .Mux3_RF_wen    (Mux3_RF_wen),
        .Mux4_RF_wadd   (Mux4_RF_wadd),
        .Mux5_RF_read2  (Mux5_RF_read2),
        .Mux6_RF_dataIn (Mux6_RF_dataIn),
        .Mux8_memwrite  (Mux8_memwrite),
        .Mux9_memDataIn (Mux9_memDataIn),
        .CZ_en          (CZ_en),
        .ALU_op         (ALU_op),
        .wIR            (wIR),
        .wAtmp          (wAtmp),
        .counter        (counter),
        .halted         (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed control word: B,A,wen,wadd,read2,dataIn,memwrite,memDataIn,CZ,op,wIR,wAtmp,counter,halted
    logic [24:0] obs;
    assign obs = {Mux1_alu_B, Mux2_alu_A, Mux3_RF_wen, Mux4_RF_wadd, Mux5_RF_read2,
                  Mux6_RF_dataIn, Mux8_memwrite, Mux9_memDataIn, CZ_en, ALU_op,
                  wIR, wAtmp, counter, halted};

    function automatic logic [24:0] cv(input int b, input int a, input int wen, input int wadd,
                                       input int rd2, input int din, input int mw, input int mdin,
                                       input int cz, input int op, input int wir, input int wat,
                                       input int cnt, input int h);
        return {3'(b), 3'(a), 2'(wen), 3'(wadd), 2'(rd2), 1'(din), 2'(mw), 1'(mdin),
                1'(cz), 1'(op), 1'(wir), 1'(wat), 3'(cnt), 1'(h)};
    endfunction

    task automatic check_vec(input string tag, input logic [24:0] got, input logic [24:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_cyc(input string tag, input logic [24:0] exp);
        @(negedge clk);
        check_vec(tag, obs, exp);
    endtask

    // Hand-written control words for each state (counter/halted as given).
    logic [24:0] E_ZERO, E_FA, E_FIR, E_PCWB, E_DEC, E_RR_ADD, E_RR_NDU, E_RRWB;
    logic [24:0] E_RI, E_RIWB, E_ADDR, E_LWWB, E_BEQ, E_BRC_BEQ, E_BRC_JAL, E_BRWB;
    logic [24:0] E_JAL, E_LINK, E_HALT;

    // Called at the falling edge of a FETCH_ADDR cycle.
    task automatic fetch(input logic [15:0] ir);
        IRout = ir;
        expect_cyc("fetch_ir", E_FIR);
        expect_cyc("pc_wb", E_PCWB);
        expect_cyc("decode", E_DEC);
    endtask

    task automatic lmsm(input logic [15:0] ir, input bit is_sm);
        fetch(ir);
        for (int k = 0; k < 8; k++) begin
            expect_cyc("lmsm_addr", cv(4,6,0,0,0,0,0,0,0,0,0,0,k,0));
            if (is_sm) expect_cyc("sm_xfer", cv(0,0,0,0,1,0,2,1,0,0,0,0,k,0));
            else       expect_cyc("lm_xfer", cv(0,0,3,2,0,0,0,0,0,0,0,0,k,0));
        end
        expect_cyc("lmsm_done", E_FA);
    endtask

    // Async reset away from the clock edge; ends at a falling edge with reset released.
    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_vec(tag, obs, E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        E_ZERO    = '0;
        E_FA      = cv(2,0,0,0,2,0,0,0,0,0,0,0,0,0);
        E_FIR     = cv(2,1,0,0,2,0,0,0,0,0,1,0,0,0);
        E_PCWB    = cv(0,0,1,3,0,1,0,0,0,0,0,0,0,0);
        E_DEC     = cv(0,0,0,0,0,0,0,0,0,0,0,1,0,0);
        E_RR_ADD  = cv(2,5,0,0,0,0,0,0,1,0,0,0,0,0);
        E_RR_NDU  = cv(2,5,0,0,0,0,0,0,1,1,0,0,0,0);
        E_RRWB    = cv(0,0,2,1,0,1,0,0,0,0,0,0,0,0);
        E_RI      = cv(3,5,0,0,0,0,0,0,1,0,0,0,0,0);
        E_RIWB    = cv(0,0,1,4,0,1,0,0,0,0,0,0,0,0);
        E_ADDR    = cv(2,3,0,0,0,0,0,0,0,0,0,0,0,0);
        E_LWWB    = cv(0,0,1,0,0,0,0,0,0,0,0,0,0,0);
        E_BEQ     = cv(2,5,0,0,0,0,0,0,0,0,0,0,0,0);
        E_BRC_BEQ = cv(2,3,0,0,2,0,0,0,0,0,0,0,0,0);
        E_BRC_JAL = cv(2,4,0,0,2,0,0,0,0,0,0,0,0,0);
        E_BRWB    = cv(0,0,1,3,0,1,0,0,0,0,0,0,0,0);
        E_JAL     = cv(2,0,0,0,2,0,0,0,0,0,0,0,0,0);
        E_LINK    = cv(0,0,1,0,0,1,0,0,0,0,0,0,0,0);
        E_HALT    = cv(0,0,0,0,0,0,0,0,0,0,0,0,0,1);

        rst_n   = 1'b0;
        IRout   = 16'h0298;
        compare = 1'b0;
        repeat (3) @(negedge clk);
        check_vec("reset_state", obs, E_ZERO);
        rst_n = 1'b1;

        // ADD: the FETCH_ADDR cycle leaving reset carries the reset (all-zero) word
        fetch(16'h0298);
        expect_cyc("add_alu", E_RR_ADD);
        expect_cyc("add_wb", E_RRWB);
        expect_cyc("add_next_fa", E_FA);

        fetch(16'h2298);
        expect_cyc("ndu_alu", E_RR_NDU);
        expect_cyc("ndu_wb", E_RRWB);
        expect_cyc("ndu_next_fa", E_FA);

        fetch(16'h1285);
        expect_cyc("adi_alu", E_RI);
        expect_cyc("adi_wb", E_RIWB);
        expect_cyc("adi_next_fa", E_FA);

        fetch(16'h3123);
        expect_cyc("lhi_alu", cv(0,2,0,0,0,0,0,0,0,0,0,0,0,0));
        expect_cyc("lhi_wb", cv(0,0,1,0,0,1,0,0,0,0,0,0,0,0));
        expect_cyc("lhi_next_fa", E_FA);

        fetch(16'h4283);
        expect_cyc("lw_addr", E_ADDR);
        expect_cyc("lw_wb", E_LWWB);
        expect_cyc("lw_next_fa", E_FA);

        fetch(16'h5283);
        expect_cyc("sw_addr", E_ADDR);
        expect_cyc("sw_mem", cv(0,0,0,0,0,0,1,0,0,0,0,0,0,0));
        expect_cyc("sw_next_fa", E_FA);

        lmsm(16'h6A05, 1'b0);
        lmsm(16'h7A05, 1'b1);

        compare = 1'b1;
        fetch(16'hC283);
        expect_cyc("beq_cmp", E_BEQ);
        expect_cyc("beq_calc", E_BRC_BEQ);
        expect_cyc("beq_wb", E_BRWB);
        expect_cyc("beq_next_fa", E_FA);

        compare = 1'b0;
        fetch(16'hC283);
        expect_cyc("beq_nt_cmp", E_BEQ);
        expect_cyc("beq_nt_fa", E_FA);

        fetch(16'h8A10);
        expect_cyc("jal_r7", E_JAL);
        expect_cyc("jal_link", E_LINK);
        expect_cyc("jal_calc", E_BRC_JAL);
        expect_cyc("jal_wb", E_BRWB);
        expect_cyc("jal_next_fa", E_FA);

        fetch(16'h9A80);
        expect_cyc("jlr_r7", E_JAL);
        expect_cyc("jlr_link", E_LINK);
        expect_cyc("jlr_calc", cv(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
        expect_cyc("jlr_wb", E_BRWB);
        expect_cyc("jlr_next_fa", E_FA);

        // Reset in the middle of an LM transfer with counter=5
        fetch(16'h6A05);
        for (int k = 0; k < 5; k++) begin
            expect_cyc("lm_pre_addr", cv(4,6,0,0,0,0,0,0,0,0,0,0,k,0));
            expect_cyc("lm_pre_xfer", cv(0,0,3,2,0,0,0,0,0,0,0,0,k,0));
        end
        expect_cyc("lm5_addr", cv(4,6,0,0,0,0,0,0,0,0,0,0,5,0));
        expect_cyc("lm5_xfer", cv(0,0,3,2,0,0,0,0,0,0,0,0,5,0));
        async_reset("reset_mid_lm");

        // Machine restarts cleanly from FETCH_ADDR
        fetch(16'h0298);
        expect_cyc("post_rst_alu", E_RR_ADD);
        expect_cyc("post_rst_wb", E_RRWB);
        expect_cyc("post_rst_fa", E_FA);

        // Undefined opcode
        fetch(16'hF000);
`ifdef ILLEGAL_TRAP_EN
        for (int c = 0; c < 100; c++) expect_cyc("halt_hold", E_HALT);
        async_reset("halt_reset");
        fetch(16'h1285);
        expect_cyc("post_halt_alu", E_RI);
`else
        expect_cyc("illegal_nop_fa", E_FA);
        expect_cyc("illegal_nop_fir", E_FIR);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Multicycle control unit for the 16-bit RISC core.
- It is the counterpart of the datapath. It consumes the instruction register value and the ALU compare flag.
- Every cycle it drives the datapath mux selects, write enables, ALU op and the LM/SM register counter.
- The datapath T1 register is free-running (it captures the ALU output every cycle), so memory address = T1 from the previous cycle.

Parameters:
- RESET_STATE, 0, encoding of FETCH_ADDR state loaded on reset.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- IRout  in  16  current instruction (opcode [15:12]).
- compare  in  1  ALU equality flag (A==B).
- Mux1_alu_B  out  3  ALU B select: 0=0, 1=1, 2=B, 3=imm6, 4=counter.
- Mux2_alu_A  out  3  ALU A select: 0=0, 1=1, 2=shift7, 3=imm6, 4=imm9, 5=A, 6=tmpA.
- Mux3_RF_wen  out  2  RF write: 0=off, 1=on, 2=CZ-gated, 3=IR bit[counter].
- Mux4_RF_wadd  out  3  RF write addr: 0=IR[11:9], 1=IR[5:3], 2=counter, 3=R7, 4=IR[8:6].
- Mux5_RF_read2  out  2  RF read2: 0=IR[8:6], 1=counter, 2=R7.
- Mux6_RF_dataIn  out  1  RF data: 0=memDataOut, 1=T1.
- Mux8_memwrite  out  2  mem write: 0=off, 1=on, 2=IR bit[counter].
- Mux9_memDataIn  out  1  mem data: 0=A, 1=B.
- CZ_en  out  1  carry/zero flag update enable.
- ALU_op  out  1  0=add, 1=nand.
- wIR  out  1  IR load.
- wAtmp  out  1  tmpA load (captures RFout1).
- counter  out  3  LM/SM register index.
- halted  out  1  core halted (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous): state=FETCH_ADDR, counter=0, halted=0.
- Every output defaults to 0 in every state unless listed below. Outputs are registered: values for state S are visible during the cycle the FSM is in S.
- FETCH_ADDR: read2=2, B=2, A=0 → T1=R7. Next state FETCH_IR.
- FETCH_IR: wIR=1 (mem at T1=R7); read2=2, B=2, A=1 → T1=R7+1. Next state PC_WB.
- PC_WB: wen=1, wadd=3, dataIn=1 → R7<=T1. Next state DECODE.
- DECODE: wAtmp=1, counter<=0. Dispatch on opcode:
  - 0000 ADD / 0010 NDU → ALU_RR.
  - 0001 ADI → ALU_RI.
  - 0011 LHI → LHI.
  - 0100 LW / 0101 SW → ADDR.
  - 0110 LM / 0111 SM → LMSM_ADDR.
  - 1100 BEQ → BEQ.
  - 1000 JAL → JAL.
  - 1001 JLR → JLR.
  - Anything else → FETCH_ADDR.
- ALU_RR: A=5, B=2, read2=0, ALU_op=opcode[1], CZ_en=1. Next state RR_WB.
- RR_WB: wen=2 (CZ-gated), wadd=1, dataIn=1. Next state FETCH_ADDR.
- ALU_RI: A=5, B=3, CZ_en=1. Next state RI_WB.
- RI_WB: wen=1, wadd=4, dataIn=1. Next state FETCH_ADDR.
- LHI: A=2, B=0. Next state, same cycle after: write with wen=1, wadd=0, dataIn=1, then FETCH_ADDR (2 cycles total).
- ADDR: A=3, B=2, read2=0 → T1=imm6+regB.
- ADDR, LW path: next state LW_WB: wen=1, wadd=0, dataIn=0. Then FETCH_ADDR.
- ADDR, SW path: next state SW_MEM: memwrite=1, memDataIn=0. Then FETCH_ADDR.
- LMSM_ADDR: A=6, B=4 → T1=tmpA+counter. Next state LMSM_XFER.
- LMSM_XFER:
  - LM: wen=3, wadd=2, dataIn=0.
  - SM: memwrite=2, read2=1, memDataIn=1.
  - If counter==7 → FETCH_ADDR and counter<=0. Else counter<=counter+1 → LMSM_ADDR.
  - All 8 indices are visited. Gating by IR[counter] is done in the datapath.
- BEQ: A=5, B=2, read2=0.
  - compare=1 → BR_CALC; else FETCH_ADDR.
  - BR_CALC: A=3, read2=2, B=2 → T1=R7+imm6. Next state BR_WB (R7<=T1), then FETCH_ADDR.
  - The offset is relative to PC+1.
- JAL: read2=2, B=2, A=0 → T1=R7. Next state JAL_LINK: wen=1, wadd=0, dataIn=1. Then BR_CALC with A=4 (imm9).
- JLR: same link as JAL (JAL_LINK), then A=0, read2=0, B=2 → T1=regB. Then BR_WB.
- counter changes only in DECODE and LMSM_XFER.
- CZ_en is asserted only in ALU_RR/ALU_RI.
- Reset mid-LM/SM aborts the transfer immediately; there is no partial completion.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined: undefined opcodes in DECODE go to HALT. HALT holds all outputs 0 and sets halted=1. Exit only by reset.
- Undefined: undefined opcodes are NOPs (return to FETCH_ADDR); halted tied to 0.

Test Plan:
- Reset: rst_n=0 asynchronously mid-LMSM_XFER with counter=5 → state FETCH_ADDR, counter=0, all selects 0, within the same cycle.
- ADD (IRout=16'h0298) → sequence FETCH_ADDR, FETCH_IR (wIR=1), PC_WB (wadd=3), DECODE, ALU_RR (CZ_en=1, ALU_op=0), RR_WB (wen=2, wadd=1); 6 cycles.
- NDU (IRout=16'h2298) → ALU_RR with ALU_op=1; ADI (16'h1285) → RI_WB wadd=4.
- LM (IRout=16'h6A05) → 8 LMSM_ADDR/LMSM_XFER pairs, counter 0..7, wen=3 in each XFER, then FETCH_ADDR; 4+16 cycles.
- BEQ (16'hC283): compare=1 → BR_CALC (A=3, read2=2) then BR_WB; compare=0 → FETCH_ADDR directly after BEQ.
- IRout=16'hF000 → with ILLEGAL_TRAP_EN: halted=1 and held for 100 cycles until reset; without: FETCH_ADDR next, halted=0.
